// File: rtl/beat_rate_estimator.sv
// -----------------------------------------------------------------------------
// beat_rate_estimator
//
// Turns a stream of single-cycle peak pulses into a beats-per-minute estimate.
// The time between accepted peaks (the inter-beat interval, IBI) is measured in
// valid samples. The last AVG_DEPTH intervals are kept in a ring buffer with a
// running sum. Whenever the buffer is full and a new interval lands, a 16-step
// restoring divider computes
//     bpm = (60 * SAMPLE_RATE_HZ * AVG_DEPTH) / sum_of_intervals
// and the result, clamped to 255, is published on bpm_out.
//
// Strobe semantics: valid_in and peak_in are plain qualifiers with no
// back-pressure. A sample counts on any enabled clock edge where valid_in is
// high, and a peak counts on any enabled edge where peak_in is high. Nothing
// is ever stalled, so there is no ready signal.
//
// FSM
//   IDLE   : no reference peak yet; the first peak starts the interval counter.
//   TRACK  : counting samples between peaks and capturing intervals.
//   DIVIDE : divider running; the counter keeps running, and one valid peak
//            may be parked as a pending capture.
//
// Ports
//   clk        : clock, all state on the rising edge
//   rst_n      : asynchronous active-low reset
//   en         : clock enable; when low all state holds and pulses read 0
//   valid_in   : sample strobe from the downsampler
//   peak_in    : single-cycle peak pulse from the peak detector
//   bpm_out    : latest beats-per-minute result (clamped to 255)
//   ibi_out    : latest accepted inter-beat interval, in samples
//   bpm_valid  : one-cycle pulse when bpm_out updates
//   beat_lost  : one-cycle pulse when no peak arrives for MAX_IBI samples
//   busy       : high while the divider runs
//   state_dbg  : current FSM state (0 IDLE, 1 TRACK, 2 DIVIDE)
//
// Parameters
//   SAMPLE_RATE_HZ : valid samples per second
//   CNT_WIDTH      : width of the interval counter and ibi_out
//   AVG_DEPTH      : number of intervals averaged; power of two, 2..16
//   MIN_IBI        : shortest accepted interval, in samples
//   MAX_IBI        : interval at which the beat is declared lost
//                    (must be below 2**CNT_WIDTH)
//
// The numerator 60*SAMPLE_RATE_HZ*AVG_DEPTH must fit in 16 bits.
// -----------------------------------------------------------------------------
module beat_rate_estimator #(
  parameter int SAMPLE_RATE_HZ = 25,
  parameter int CNT_WIDTH      = 12,
  parameter int AVG_DEPTH      = 4,
  parameter int MIN_IBI        = 8,
  parameter int MAX_IBI        = 100
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 valid_in,
  input  logic                 peak_in,
  output logic [7:0]           bpm_out,
  output logic [CNT_WIDTH-1:0] ibi_out,
  output logic                 bpm_valid,
  output logic                 beat_lost,
  output logic                 busy,
  output logic [1:0]           state_dbg
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int PTR_W   = $clog2(AVG_DEPTH);
  localparam int FILL_W  = $clog2(AVG_DEPTH) + 1;
  // The sum of AVG_DEPTH intervals needs PTR_W extra bits over one interval.
  localparam int SUM_W   = CNT_WIDTH + PTR_W;
  localparam int NUM_VAL = 60 * SAMPLE_RATE_HZ * AVG_DEPTH;

  localparam logic [15:0]          NUMERATOR = 16'(NUM_VAL);
  localparam logic [CNT_WIDTH-1:0] MIN_CNT   = CNT_WIDTH'(MIN_IBI);
  localparam logic [CNT_WIDTH-1:0] MAX_CNT   = CNT_WIDTH'(MAX_IBI);
  localparam logic [FILL_W-1:0]    FULL      = FILL_W'(AVG_DEPTH);
  localparam logic [3:0]           LAST_ITER = 4'd15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    DIVIDE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] ring [AVG_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [SUM_W-1:0]     sum;
  logic [FILL_W-1:0]    fill;
  logic                 pend;
  logic [CNT_WIDTH-1:0] pend_ibi;

  // Divider: quo starts as the numerator and shifts out MSB-first into rem
  // while quotient bits shift in from the bottom.
  logic [SUM_W-1:0]     rem;
  logic [15:0]          quo;
  logic [3:0]           iter;

  logic [7:0]           bpm_q;
  logic [CNT_WIDTH-1:0] ibi_q;
  logic                 valid_q;
  logic                 lost_q;
  logic                 busy_q;

  // ---------------------------------------------------------------------------
  // Next-value helpers
  // ---------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0] cnt_run;      // counter after this cycle's sample
  logic [CNT_WIDTH-1:0] cnt_restart;  // counter value after a captured peak
  logic                 timeout;
  logic                 peak_ok;
  logic [CNT_WIDTH-1:0] cap_ibi;
  logic [CNT_WIDTH-1:0] old_ibi;
  logic [SUM_W-1:0]     sum_next;
  logic [FILL_W-1:0]    fill_next;
  logic [SUM_W:0]       rem_shift;
  logic [SUM_W:0]       rem_diff;
  logic                 div_ge;
  logic [SUM_W-1:0]     rem_next;
  logic [15:0]          quo_next;
  logic [7:0]           bpm_clamped;

  always_comb begin
    // Interval counter: counts valid samples, saturating at MAX_IBI.
    cnt_run = cnt;
    if (valid_in && (cnt != MAX_CNT)) begin
      cnt_run = cnt + CNT_WIDTH'(1);
    end
    // A peak that coincides with a sample already counts that sample toward
    // the next interval.
    cnt_restart = valid_in ? CNT_WIDTH'(1) : '0;

    // The counter only runs outside IDLE, so reaching MAX_IBI means the beat
    // has been lost. This is checked on the registered value so it wins over
    // a peak arriving in the same cycle.
    timeout = (state != IDLE) && (cnt == MAX_CNT);
    peak_ok = peak_in && (cnt >= MIN_CNT);

    // A parked capture from the last DIVIDE takes precedence in TRACK.
    cap_ibi = pend ? pend_ibi : cnt;
    old_ibi = ring[wr_ptr];

    // Running sum: drop the entry being overwritten, add the new one.
    sum_next = sum - {{PTR_W{1'b0}}, old_ibi} + {{PTR_W{1'b0}}, cap_ibi};
    fill_next = (fill == FULL) ? fill : fill + FILL_W'(1);

    // One restoring-division step.
    rem_shift = {rem, quo[15]};
    div_ge    = (rem_shift >= {1'b0, sum});
    rem_diff  = rem_shift - {1'b0, sum};
    // rem_shift < 2*sum, so after a conditional subtract the top bit is 0.
    rem_next  = div_ge ? rem_diff[SUM_W-1:0] : rem_shift[SUM_W-1:0];
    quo_next  = {quo[14:0], div_ge};

    bpm_clamped = (quo_next > 16'd255) ? 8'hFF : quo_next[7:0];
  end

  // ---------------------------------------------------------------------------
  // FSM and datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      for (int i = 0; i < AVG_DEPTH; i++) begin
        ring[i] <= '0;
      end
      wr_ptr   <= '0;
      sum      <= '0;
      fill     <= '0;
      pend     <= 1'b0;
      pend_ibi <= '0;
      rem      <= '0;
      quo      <= '0;
      iter     <= '0;
      bpm_q    <= '0;
      ibi_q    <= '0;
      valid_q  <= 1'b0;
      lost_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else if (en) begin
      // Pulses last exactly one enabled cycle.
      valid_q <= 1'b0;
      lost_q  <= 1'b0;

      if (timeout) begin
        // Start over from scratch but keep the last published results.
        lost_q <= 1'b1;
        cnt    <= '0;
        for (int i = 0; i < AVG_DEPTH; i++) begin
          ring[i] <= '0;
        end
        wr_ptr <= '0;
        sum    <= '0;
        fill   <= '0;
        pend   <= 1'b0;
        rem    <= '0;
        quo    <= '0;
        iter   <= '0;
        busy_q <= 1'b0;
        state  <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            // The first peak is only a reference point; no interval yet.
            if (peak_in) begin
              cnt   <= '0;
              state <= TRACK;
            end
          end

          TRACK: begin
            if (pend || peak_ok) begin
              if (pend) begin
                // The counter was already restarted when this peak was
                // parked; a peak in this same cycle is not considered.
                pend <= 1'b0;
                cnt  <= cnt_run;
              end else begin
                cnt  <= cnt_restart;
              end
              ring[wr_ptr] <= cap_ibi;
              wr_ptr       <= wr_ptr + PTR_W'(1);
              sum          <= sum_next;
              fill         <= fill_next;
              ibi_q        <= cap_ibi;
              if (fill_next == FULL) begin
                rem    <= '0;
                quo    <= NUMERATOR;
                iter   <= '0;
                busy_q <= 1'b1;
                state  <= DIVIDE;
              end
            end else begin
              // Peaks below MIN_IBI fall through here and are ignored.
              cnt <= cnt_run;
            end
          end

          DIVIDE: begin
            rem  <= rem_next;
            quo  <= quo_next;
            iter <= iter + 4'd1;

            // Park the first valid peak; later ones are dropped and leave
            // the counter running.
            if (peak_ok && !pend) begin
              pend     <= 1'b1;
              pend_ibi <= cnt;
              cnt      <= cnt_restart;
            end else begin
              cnt      <= cnt_run;
            end

            if (iter == LAST_ITER) begin
              bpm_q   <= bpm_clamped;
              valid_q <= 1'b1;
              busy_q  <= 1'b0;
              state   <= TRACK;
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Pulses are masked by en so they read 0 while disabled; the held pulse
  // then shows for the first enabled cycle.
  assign bpm_out   = bpm_q;
  assign ibi_out   = ibi_q;
  assign bpm_valid = valid_q & en;
  assign beat_lost = lost_q & en;
  assign busy      = busy_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_beat_rate_estimator.sv
// -----------------------------------------------------------------------------
// tb_beat_rate_estimator
//
// Directed bench for beat_rate_estimator. Two instances share all inputs:
// dut_a uses default parameters, dut_b uses SAMPLE_RATE_HZ=50 to exercise the
// 255 clamp. Inputs change 1 time unit after the rising edge and outputs are
// read at that point, i.e. well away from the active edge.
// -----------------------------------------------------------------------------
module tb_beat_rate_estimator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        valid_in = 1'b0;
  logic        peak_in = 1'b0;

  logic [7:0]  bpm_out;
  logic [11:0] ibi_out;
  logic        bpm_valid;
  logic        beat_lost;
  logic        busy;
  logic [1:0]  state_dbg;

  logic [7:0]  b_bpm_out;
  logic [11:0] b_ibi_out;
  logic        b_bpm_valid;
  logic        b_beat_lost;
  logic        b_busy;
  logic [1:0]  b_state_dbg;

  int checks = 0;
  int failures = 0;
  int vcount = 0;
  int lcount = 0;

  always #5 clk = ~clk;

  beat_rate_estimator dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .valid_in  (valid_in),
    .peak_in   (peak_in),
    .bpm_out   (bpm_out),
    .ibi_out   (ibi_out),
    .bpm_valid (bpm_valid),
    .beat_lost (beat_lost),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  beat_rate_estimator #(.SAMPLE_RATE_HZ(50)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .valid_in  (valid_in),
    .peak_in   (peak_in),
    .bpm_out   (b_bpm_out),
    .ibi_out   (b_ibi_out),
    .bpm_valid (b_bpm_valid),
    .beat_lost (b_beat_lost),
    .busy      (b_busy),
    .state_dbg (b_state_dbg)
  );

  // Pulse counters sampled on the falling edge.
  always @(negedge clk) begin
    if (bpm_valid) vcount++;
    if (beat_lost) lcount++;
  end

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock cycle with the given strobes.
  task automatic cyc(input logic v, input logic p);
    valid_in = v;
    peak_in  = p;
    @(posedge clk);
    #1;
  endtask

  // n valid samples followed by a peak on a non-sample cycle: interval = n.
  task automatic gap(input int n);
    repeat (n) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
  endtask

  // Wait at most 18 cycles for bpm_valid, then check the result.
  task automatic wait_bpm(input int exp_bpm, input string tag);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 18; n++) begin
      cyc(1'b0, 1'b0);
      if (bpm_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk(32'(seen), 32'd1, {tag, "_seen"});
    chk(32'(bpm_out), 32'(exp_bpm), tag);
  endtask

  task automatic do_reset();
    valid_in = 1'b0;
    peak_in  = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_mix [4];
    int v0;
    int l0;
    exp_mix = '{120, 100, 85, 75};

    // ---- reset state ----
    do_reset();
    chk(32'(bpm_out),   0, "rst_bpm");
    chk(32'(ibi_out),   0, "rst_ibi");
    chk(32'(bpm_valid), 0, "rst_valid");
    chk(32'(beat_lost), 0, "rst_lost");
    chk(32'(busy),      0, "rst_busy");
    chk(32'(state_dbg), 0, "rst_state");

    // ---- peaks every 25 samples -> 60 bpm ----
    cyc(1'b0, 1'b1);
    chk(32'(state_dbg), 1, "idle_to_track");
    // Disabled cycles must not advance the counter.
    en = 1'b0;
    repeat (10) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    en = 1'b1;
    chk(32'(state_dbg), 1, "en_hold_state");
    for (int k = 0; k < 4; k++) begin
      gap(25);
      chk(32'(ibi_out), 25, "ibi25");
      if (k < 3) chk(32'(busy), 0, "no_divide_before_full");
    end
    chk(32'(busy), 1, "busy_in_divide");
    chk(32'(state_dbg), 2, "state_divide");
    chk(32'(vcount), 0, "no_valid_before_full");
    wait_bpm(60, "bpm60");
    chk(32'(busy), 0, "busy_cleared");

    // ---- steady 10 -> 150, then switch to 20 ----
    do_reset();
    chk(32'(bpm_out), 0, "rst_clears_bpm");
    cyc(1'b0, 1'b1);
    repeat (4) gap(10);
    wait_bpm(150, "bpm150");
    for (int k = 0; k < 4; k++) begin
      gap(20);
      chk(32'(ibi_out), 20, "ibi20");
      wait_bpm(exp_mix[k], "bpm_mix");
    end

    // ---- spurious peak after 5 samples is ignored ----
    gap(5);
    chk(32'(ibi_out), 20, "spur_ibi_held");
    chk(32'(busy), 0, "spur_no_divide");
    gap(20);
    chk(32'(ibi_out), 25, "ibi_after_spur");
    wait_bpm(70, "bpm_after_spur");   // ring 20,20,20,25 -> 6000/85

    // ---- timeout after 100 samples without a peak ----
    l0 = lcount;
    repeat (100) cyc(1'b1, 1'b0);
    chk(32'(lcount - l0), 0, "no_lost_early");
    cyc(1'b0, 1'b0);
    chk(32'(beat_lost), 1, "lost_pulse");
    chk(32'(state_dbg), 0, "lost_to_idle");
    chk(32'(bpm_out), 70, "lost_bpm_held");
    chk(32'(ibi_out), 25, "lost_ibi_held");
    cyc(1'b0, 1'b0);
    chk(32'(beat_lost), 0, "lost_one_cycle");

    v0 = vcount;
    cyc(1'b0, 1'b1);
    repeat (3) gap(30);
    chk(32'(vcount - v0), 0, "no_valid_after_lost");
    gap(30);

    // ---- peak during DIVIDE is parked and processed afterwards ----
    repeat (10) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    chk(32'(busy), 1, "peak_in_divide");
    wait_bpm(50, "bpm50");             // 6000/120
    chk(32'(ibi_out), 30, "pend_not_yet");
    wait_bpm(60, "bpm_pending");       // ring 10,30,30,30 -> 6000/100
    chk(32'(ibi_out), 10, "ibi_pending");
    gap(8);
    chk(32'(ibi_out), 8, "ibi_min");
    wait_bpm(76, "bpm76");             // ring 10,8,30,30 -> 6000/78

    // ---- reset in the middle of DIVIDE ----
    gap(8);
    chk(32'(busy), 1, "busy_before_rst");
    repeat (5) cyc(1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk(32'(bpm_out),   0, "midrst_bpm");
    chk(32'(ibi_out),   0, "midrst_ibi");
    chk(32'(busy),      0, "midrst_busy");
    chk(32'(bpm_valid), 0, "midrst_valid");
    chk(32'(state_dbg), 0, "midrst_state");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    v0 = vcount;
    repeat (25) cyc(1'b0, 1'b0);
    chk(32'(vcount - v0), 0, "no_valid_after_rst");

    // ---- intervals of 8: 187 at 25 Hz, 375 clamped to 255 at 50 Hz ----
    cyc(1'b0, 1'b1);
    repeat (3) gap(8);
    chk(32'(vcount - v0), 0, "fill_after_rst");
    gap(8);
    wait_bpm(187, "bpm187");
    chk(32'(b_bpm_valid), 1, "clamp_valid");
    chk(32'(b_bpm_out), 255, "clamp255");
    chk(32'(b_ibi_out), 8, "clamp_ibi");
    chk(32'(b_beat_lost), 0, "clamp_no_lost");
    chk(32'(b_busy), 0, "clamp_busy");
    chk(32'(b_state_dbg), 1, "clamp_state");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
